montexp_seq: RTL and testbench
==============================

Name: montexp_seq

Overview:
- Square-and-multiply sequencer for modular exponentiation r = x^e mod m in the Montgomery domain.
- Drives one shared Montgomery multiplier wrapper through its start/done level handshake.
- Sits between the RSA/ECC top-level control and the multiplier. It owns the operand muxing, the accumulator register and exponent-bit scanning.

Parameters:
- WID, 256, operand/modulus width (TEST config: 4)
- EWID, 256, exponent width (TEST config: 4)
- ECNTWID, 8, exponent bit-index width; 2^ECNTWID >= EWID (TEST config: 2)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- start  input  1  1-cycle request; sampled only in IDLE
- xbar  input  WID  base in Montgomery form (x*R mod m); must be held stable while busy
- onem  input  WID  Montgomery one (R mod m); must be held stable while busy
- e  input  EWID  exponent; captured on accepted start
- busy  output  1  high from the cycle after an accepted start until the done pulse
- done  output  1  1-cycle pulse when result is valid
- result  output  WID  final accumulator; held until the next accepted start
- mm_a  output  WID  multiplier operand a
- mm_b  output  WID  multiplier operand b
- mm_start  output  1  1-cycle multiplier start
- mm_done  input  1  multiplier idle level (high = idle/result valid)
- mm_r  input  WID  multiplier result

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, busy=0, done=0, mm_start=0, result=0, acc=0, bit index=0, mm_a=mm_b=0.
- An active reset mid-operation aborts immediately with no done pulse. The external multiplier is not reset by this block; the next start waits for mm_done=1.
- States: IDLE, LOAD, ISSUE, WLO, WHI, NEXT, FIN.
- IDLE: on start=1, latch e into the exponent shift register, set acc=onem, set idx=EWID-1, set op=SQR, go to LOAD. start while busy is ignored.
- LOAD: go to ISSUE.
- ISSUE: drive mm_a/mm_b per op:
  - SQR: a=acc, b=acc
  - MUL: a=acc, b=xbar
  - CONV: a=acc, b=1
  - Operands are registered and held constant until capture.
  - If mm_done=1, pulse mm_start for exactly 1 cycle and go to WLO. Otherwise stay in ISSUE.
- WLO: wait for mm_done=0 (multiplier accepted), then go to WHI.
- WHI: wait for mm_done=1, then capture acc <= mm_r and go to NEXT.
- NEXT:
  - If op=SQR and the current exponent bit is 1: op=MUL, go to ISSUE.
  - Else if idx>0: idx-1, shift the exponent, op=SQR, go to ISSUE.
  - Else go to FIN (or to conversion; see Optional Feature).
- FIN: result <= acc, done=1 for one cycle, busy=0, go to IDLE.
- Bits are scanned MSB first over all EWID bits; leading zeros are not skipped, so timing is data-independent for squarings.
- Op count = EWID squarings + popcount(e) multiplies.
- Latency per op = 2 (ISSUE/WLO edge) + multiplier run length + 1 (NEXT).
- e=0: EWID squarings of onem; result = onem.
- mm_r is taken as WID bits; the multiplier guarantees it is < m. No wrap handling is done here.
- mm_done already low when entering ISSUE: hold in ISSUE and do not pulse mm_start.

Optional Feature:
- MONTEXP_FROMMONT_EN defined: after the last bit, NEXT goes to ISSUE with op=CONV (acc*1*R^-1), then to FIN. result is in the normal domain (x^e mod m). Adds 1 multiply.
- Undefined: the CONV op does not exist; result stays in the Montgomery domain (x^e*R mod m).

Decomposition:
- Shared package montexp_pkg: state encodings (3-bit), op encodings (SQR=0, MUL=1, CONV=2), TEST/default width constants.
- One sub-module montexp_opmux: combinational/registered operand select for {acc, xbar, 1} by op.
- Everything else stays in montexp_seq.

Test Plan (TEST config WID=4, EWID=4, m=13, onem=3, behavioural multiplier with 16-cycle run):
- Reset held low 3 cycles while start=1 -> busy=0, done=0, result=0, mm_start never asserted.
- x=2 (xbar=6), e=4'b0101, start -> exactly 6 mm_start pulses (S,S,M,S,S,M). done pulse with result=5; with MONTEXP_FROMMONT_EN, 7 pulses and result=6.
- e=0 -> 4 squarings, no multiply, result=3 (onem); with MONTEXP_FROMMONT_EN, result=1.
- start re-asserted every cycle during a run -> ignored; one done pulse only; mm_a/mm_b stable between each mm_start and the mm_done rising edge.
- Model holds mm_done=0 for 5 cycles before the first op -> stays in ISSUE, then a single mm_start. Result unchanged vs the normal run.
- rst=0 during the 3rd op of e=4'b1111 -> idle next cycle, no done pulse. A new start with e=4'b0001, xbar=6 -> result=6*... Montgomery chain gives result=6 (Montgomery form of 2); with MONTEXP_FROMMONT_EN, result=2.

Source files
------------

// File: rtl/montexp_pkg.sv
// montexp_pkg: shared state/op encodings and width constants for the Montgomery exponent sequencer
package montexp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WLO   = 3'd3,
        S_WHI   = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_SQR  = 2'd0,
        OP_MUL  = 2'd1,
        OP_CONV = 2'd2
    } op_t;

    localparam int DEF_WID      = 256;
    localparam int DEF_EWID     = 256;
    localparam int DEF_ECNTWID  = 8;

    localparam int TEST_WID     = 4;
    localparam int TEST_EWID    = 4;
    localparam int TEST_ECNTWID = 2;

endpackage

// File: rtl/montexp_opmux.sv
// montexp_opmux: registered multiplier operand select over {acc, xbar, 1}; the 1 exists only with MONTEXP_FROMMONT_EN
module montexp_opmux
    import montexp_pkg::*;
#(
    parameter int WID = DEF_WID
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  op_t            op,
    input  logic [WID-1:0] acc,
    input  logic [WID-1:0] xbar,
    output logic [WID-1:0] mm_a,
    output logic [WID-1:0] mm_b
);

    logic [WID-1:0] bsel;

    // operand b for the pending op; operand a is always the accumulator
    always_comb begin
`ifdef MONTEXP_FROMMONT_EN
        bsel = op == OP_MUL ? xbar : op == OP_CONV ? WID'(1) : acc;
`else
        bsel = op == OP_MUL ? xbar : acc;
`endif
    end

    // operands are latched at issue and held until the next issue, covering the whole multiplier run
    always_ff @(posedge clk) begin
        if (!rst) begin
            mm_a <= '0;
            mm_b <= '0;
        end else if (load) begin
            mm_a <= acc;
            mm_b <= bsel;
        end
    end

endmodule

// File: rtl/montexp_seq.sv
// montexp_seq: MSB-first square-and-multiply sequencer driving one shared Montgomery multiplier
// MONTEXP_FROMMONT_EN: append a multiply-by-one so the result leaves the Montgomery domain
module montexp_seq
    import montexp_pkg::*;
#(
    parameter int WID     = DEF_WID,
    parameter int EWID    = DEF_EWID,
    parameter int ECNTWID = DEF_ECNTWID
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WID-1:0]  xbar,
    input  logic [WID-1:0]  onem,
    input  logic [EWID-1:0] e,
    output logic            busy,
    output logic            done,
    output logic [WID-1:0]  result,
    output logic [WID-1:0]  mm_a,
    output logic [WID-1:0]  mm_b,
    output logic            mm_start,
    input  logic            mm_done,
    input  logic [WID-1:0]  mm_r
);

    state_t              state;
    state_t              nxt;
    op_t                 op;
    logic [WID-1:0]      acc;
    logic [EWID-1:0]     er;
    logic [ECNTWID-1:0]  idx;
    logic                issue_go;
    logic                cap;
    logic                to_mul;
    logic                to_sqr;
    logic                to_conv;

    montexp_opmux #(.WID(WID)) u_opmux (
        .clk  (clk),
        .rst  (rst),
        .load (issue_go),
        .op   (op),
        .acc  (acc),
        .xbar (xbar),
        .mm_a (mm_a),
        .mm_b (mm_b)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // scan decision in NEXT: multiply after a squaring on a set bit, else advance to the next bit
    always_comb begin
        to_mul = op == OP_SQR && er[EWID-1];
        to_sqr = !to_mul && idx != '0;
`ifdef MONTEXP_FROMMONT_EN
        to_conv = !to_mul && !to_sqr && op != OP_CONV;
`else
        to_conv = 1'b0;
`endif
    end

    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:  nxt = S_ISSUE;
            S_ISSUE: nxt = mm_done ? S_WLO : S_ISSUE;
            S_WLO:   nxt = mm_done ? S_WLO : S_WHI;
            S_WHI:   nxt = mm_done ? S_NEXT : S_WHI;
            S_NEXT:  nxt = (to_mul || to_sqr || to_conv) ? S_ISSUE : S_FIN;
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // state-decoded outputs and strobes
    always_comb begin
        busy     = state != S_IDLE;
        issue_go = state == S_ISSUE && mm_done;
        cap      = state == S_WHI && mm_done;
    end

    // accumulator, exponent scan registers, handshake pulse and result
    always_ff @(posedge clk) begin
        if (!rst) begin
            op       <= OP_SQR;
            acc      <= '0;
            er       <= '0;
            idx      <= '0;
            result   <= '0;
            done     <= 1'b0;
            mm_start <= 1'b0;
        end else begin
            mm_start <= issue_go;
            done     <= state == S_FIN;
            if (state == S_IDLE && start) begin
                er  <= e;
                acc <= onem;
                idx <= ECNTWID'(EWID - 1);
                op  <= OP_SQR;
            end
            if (cap)
                acc <= mm_r;
            if (state == S_NEXT) begin
                if (to_mul) begin
                    op <= OP_MUL;
                end else if (to_sqr) begin
                    idx <= idx - ECNTWID'(1);
                    er  <= er << 1;
                    op  <= OP_SQR;
                end else if (to_conv) begin
                    op <= OP_CONV;
                end
            end
            if (state == S_FIN)
                result <= acc;
        end
    end

endmodule

// File: tb/tb_montexp_seq.sv
// tb_montexp_seq: directed checks of montexp_seq against a 16-cycle behavioural Montgomery multiplier (m=13, R=16)
module tb_montexp_seq;

    localparam int WID     = montexp_pkg::TEST_WID;
    localparam int EWID    = montexp_pkg::TEST_EWID;
    localparam int ECNTWID = montexp_pkg::TEST_ECNTWID;

`ifdef MONTEXP_FROMMONT_EN
    localparam logic [WID-1:0] RES_5 = 4'd6;
    localparam int             OPS_5 = 7;
    localparam logic [WID-1:0] RES_0 = 4'd1;
    localparam int             OPS_0 = 5;
    localparam logic [WID-1:0] RES_1 = 4'd2;
    localparam int             OPS_1 = 6;
`else
    localparam logic [WID-1:0] RES_5 = 4'd5;
    localparam int             OPS_5 = 6;
    localparam logic [WID-1:0] RES_0 = 4'd3;
    localparam int             OPS_0 = 4;
    localparam logic [WID-1:0] RES_1 = 4'd6;
    localparam int             OPS_1 = 5;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [WID-1:0]  xbar;
    logic [WID-1:0]  onem;
    logic [EWID-1:0] e;
    logic            busy;
    logic            done;
    logic [WID-1:0]  result;
    logic [WID-1:0]  mm_a;
    logic [WID-1:0]  mm_b;
    logic            mm_start;
    logic            mm_done;
    logic [WID-1:0]  mm_r;

    logic            md = 1'b1;
    logic            hold = 1'b0;
    logic            chk_stab = 1'b1;
    logic [WID-1:0]  la = '0;
    logic [WID-1:0]  lb = '0;
    logic [WID-1:0]  mr = '0;
    int              cnt = 0;
    int              starts = 0;
    int              dones = 0;
    int              unstable = 0;
    int              bad = 0;
    int              tests = 0;
    int              fails = 0;

    assign mm_done = md & ~hold;
    assign mm_r    = mr;

    always #5 clk = ~clk;

    montexp_seq #(.WID(WID), .EWID(EWID), .ECNTWID(ECNTWID)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .xbar     (xbar),
        .onem     (onem),
        .e        (e),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_start (mm_start),
        .mm_done  (mm_done),
        .mm_r     (mm_r)
    );

    function automatic logic [WID-1:0] mont(input logic [WID-1:0] a, input logic [WID-1:0] b);
        int p;
        p = (int'(a) * int'(b) * 9) % 13;
        return WID'(p);
    endfunction

    // behavioural multiplier: accepts on start while idle, result after 16 cycles
    always @(posedge clk) begin
        if (mm_start) begin
            starts <= starts + 1;
            if (!mm_done)
                bad <= bad + 1;
        end
        if (done)
            dones <= dones + 1;
        if (mm_start && mm_done) begin
            la  <= mm_a;
            lb  <= mm_b;
            md  <= 1'b0;
            cnt <= 16;
        end else if (!md) begin
            if (cnt == 1) begin
                md <= 1'b1;
                mr <= mont(la, lb);
            end
            cnt <= cnt - 1;
        end
    end

    // operands must stay put while the multiplier is running
    always @(negedge clk) begin
        if (chk_stab && !md && (mm_a !== la || mm_b !== lb))
            unstable <= unstable + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [EWID-1:0] ev, input int stall_n, input bit spam,
                       input logic [WID-1:0] exp_res, input int exp_ops);
        int s0;
        int d0;
        int u0;
        int n;
        s0 = starts;
        d0 = dones;
        u0 = unstable;
        e = ev;
        hold = stall_n > 0;
        start = 1'b1;
        @(negedge clk);
        start = spam;
        n = 0;
        while (!done && n < 2000) begin
            if (stall_n > 0 && n == stall_n) begin
                check({tag, "_stall_nostart"}, starts - s0, 0);
                check({tag, "_stall_busy"}, busy, 1);
                hold = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_ops"}, starts - s0, exp_ops);
        repeat (3) @(negedge clk);
        check({tag, "_one_done"}, dones - d0, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_held"}, result, exp_res);
        check({tag, "_stable"}, unstable - u0, 0);
    endtask

    initial begin
        int s0;
        int d0;
        int n;
        rst   = 1'b0;
        start = 1'b1;
        xbar  = 4'd6;
        onem  = 4'd3;
        e     = 4'b0101;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_mm_a", mm_a, 0);
        check("rst_mm_b", mm_b, 0);
        check("rst_no_mm_start", starts, 0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        run("e5", 4'b0101, 0, 1'b0, RES_5, OPS_5);
        run("e0", 4'b0000, 0, 1'b0, RES_0, OPS_0);
        run("spam", 4'b0101, 0, 1'b1, RES_5, OPS_5);
        run("stall", 4'b0101, 5, 1'b0, RES_5, OPS_5);

        s0 = starts;
        e = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (starts - s0 < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", starts - s0, 3);
        chk_stab = 1'b0;
        repeat (4) @(negedge clk);
        d0 = dones;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (5) @(negedge clk);
        check("abort_nodone", dones - d0, 0);
        xbar = 4'd6;
        run("after", 4'b0001, 0, 1'b0, RES_1, OPS_1);
        check("no_start_while_running", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
